tcb_lib_arbitrated_mux: RTL and testbench

- Many-to-one TCB interconnect node: SPN TCB manager ports converge on one TCB subordinate port.
- A fixed-priority arbiter grants one requesting port per cycle. The granted request is forwarded to the single downstream port.
- The response is returned to the port that issued the request, DLY cycles after the handshake.
- Sits between CPU/DMA-style managers and a shared memory or peripheral.

---
 rtl/tcb_lib_mux_pkg.sv | 64 ++++++
 rtl/tcb_lib_prio_sel.sv | 62 ++++++
 rtl/tcb_lib_arbitrated_mux.sv | 139 +++++++++++++
 tb/tb_tcb_lib_arbitrated_mux.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcb_lib_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tcb_lib_mux_pkg
// Description : Shared types and helpers for the arbitrated TCB mux.
//               Struct fields are sized for the widest supported bus so the
//               same types serve every parameterisation. Narrower instances
//               zero-pad on the way in and slice on the way out.
//               Contents:
//                 tcb_req_t  - request fields {wen, adr, ben, wdt}
//                 tcb_rsp_t  - response fields {rdt, err}
//                 tcb_tag_t  - response-routing tag {vld, idx}
//                 prio_index - winning port index for a vld vector
// Revision    : 1.0 - initial release
// ============================================================================
package tcb_lib_mux_pkg;

  localparam int unsigned MAX_SPN = 16;  // widest supported port count
  localparam int unsigned MAX_SPL = 4;   // $clog2(MAX_SPN)
  localparam int unsigned MAX_ADR = 64;
  localparam int unsigned MAX_DAT = 64;
  localparam int unsigned MAX_BEN = 8;
  localparam int unsigned PRI_W   = 8;   // width of one priority value

  typedef struct packed {
    logic               wen;
    logic [MAX_ADR-1:0] adr;
    logic [MAX_BEN-1:0] ben;
    logic [MAX_DAT-1:0] wdt;
  } tcb_req_t;

  typedef struct packed {
    logic [MAX_DAT-1:0] rdt;
    logic               err;
  } tcb_rsp_t;

  typedef struct packed {
    logic               vld;
    logic [MAX_SPL-1:0] idx;
  } tcb_tag_t;

  typedef logic [MAX_SPN-1:0][PRI_W-1:0] pri_vec_t;

  // Index of the active port with the smallest priority value. The strict
  // comparison makes the lowest index win among equal priorities. Callers
  // zero-pad vld above their port count so padding entries never win.
  function automatic logic [MAX_SPL-1:0] prio_index(
    input logic [MAX_SPN-1:0] vld,
    input pri_vec_t           pri
  );
    logic [MAX_SPL-1:0] best;
    logic               found;
    best  = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_SPN; i++) begin
      if (vld[i] && (!found || (pri[i] < pri[best]))) begin
        best  = MAX_SPL'(i);
        found = 1'b1;
      end
    end
    return best;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tcb_lib_prio_sel.sv
`default_nettype none
// ============================================================================
// Module      : tcb_lib_prio_sel
// Description : Fixed-priority grant selector. Picks the active port with
//               the lowest PRI value (lowest index on ties). With no port
//               active the previous grant is held.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset (last grant -> 0)
//               vld  - per-port request valid [SPN]
//               sel  - grant index [SPL]
// Revision    : 1.0 - initial release
// ============================================================================
module tcb_lib_prio_sel
  import tcb_lib_mux_pkg::*;
#(
  parameter int unsigned SPN = 3,
  parameter int unsigned SPL = $clog2(SPN),
  parameter int unsigned PRI [SPN-1:0] = '{2, 1, 0}
)(
  input  logic           clk,
  input  logic           rst,
  input  logic [SPN-1:0] vld,
  output logic [SPL-1:0] sel
);

  pri_vec_t           w_pri;
  logic [MAX_SPN-1:0] w_vld_ext;
  logic [MAX_SPL-1:0] w_idx;
  logic [SPL-1:0]     last_d;
  logic [SPL-1:0]     last_q;
  logic               unused_idx;

  for (genvar i = 0; i < MAX_SPN; i++) begin : g_pri
    if (i < SPN) begin : g_used
      assign w_pri[i] = PRI[i][PRI_W-1:0];
    end else begin : g_pad
      assign w_pri[i] = '0;
    end
  end

  always_comb begin
    w_vld_ext          = '0;
    w_vld_ext[SPN-1:0] = vld;
    w_idx              = prio_index(w_vld_ext, w_pri);
    sel                = (|vld) ? w_idx[SPL-1:0] : last_q;
    // Follows sel, so the register only moves when some port is active.
    last_d             = sel;
  end

  // Upper index bits are always zero for this port count.
  assign unused_idx = ^w_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
    end else begin
      last_q <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tcb_lib_arbitrated_mux.sv
`default_nettype none
// ============================================================================
// Module      : tcb_lib_arbitrated_mux
// Description : Many-to-one TCB node. SPN manager ports share one subordinate
//               port through a fixed-priority arbiter. The granted request
//               is forwarded combinationally. Each response is routed back
//               to its issuer DLY cycles after the handshake.
// Ports       : clk, rst                  - clock / sync active-high reset
//               s_vld/s_wen/s_adr/s_ben/s_wdt - upstream requests [SPN]
//               s_rdy/s_rdt/s_err         - upstream ready / response [SPN]
//               m_vld/m_wen/m_adr/m_ben/m_wdt - downstream request
//               m_rdy/m_rdt/m_err         - downstream ready / response
//               sel                       - current grant index (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module tcb_lib_arbitrated_mux
  import tcb_lib_mux_pkg::*;
#(
  parameter int unsigned ADR = 32,
  parameter int unsigned DAT = 32,
  parameter int unsigned UNT = 8,
  parameter int unsigned BEN = DAT/UNT,
  parameter int unsigned DLY = 1,
  parameter int unsigned SPN = 3,
  parameter int unsigned SPL = $clog2(SPN),
  parameter int unsigned PRI [SPN-1:0] = '{2, 1, 0}
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SPN-1:0]           s_vld,
  input  logic [SPN-1:0]           s_wen,
  input  logic [SPN-1:0][ADR-1:0]  s_adr,
  input  logic [SPN-1:0][BEN-1:0]  s_ben,
  input  logic [SPN-1:0][DAT-1:0]  s_wdt,
  output logic [SPN-1:0]           s_rdy,
  output logic [SPN-1:0][DAT-1:0]  s_rdt,
  output logic [SPN-1:0]           s_err,
  output logic                     m_vld,
  output logic                     m_wen,
  output logic [ADR-1:0]           m_adr,
  output logic [BEN-1:0]           m_ben,
  output logic [DAT-1:0]           m_wdt,
  input  logic                     m_rdy,
  input  logic [DAT-1:0]           m_rdt,
  input  logic                     m_err,
  output logic [SPL-1:0]           sel
);

  tcb_req_t w_req;
  tcb_rsp_t w_rsp;
  tcb_tag_t w_tag_in;
  tcb_tag_t w_tag_out;
  logic     w_hs;
  logic     unused_pad;

  tcb_lib_prio_sel #(
    .SPN (SPN),
    .SPL (SPL),
    .PRI (PRI)
  ) u_prio_sel (
    .clk (clk),
    .rst (rst),
    .vld (s_vld),
    .sel (sel)
  );

  // Request mux and ready demux. Only the granted port sees m_rdy; the
  // others stall until they win a later arbitration.
  always_comb begin
    w_req              = '0;
    w_req.wen          = s_wen[sel];
    w_req.adr[ADR-1:0] = s_adr[sel];
    w_req.ben[BEN-1:0] = s_ben[sel];
    w_req.wdt[DAT-1:0] = s_wdt[sel];

    m_vld = ~rst & (|s_vld);
    m_wen = w_req.wen;
    m_adr = w_req.adr[ADR-1:0];
    m_ben = w_req.ben[BEN-1:0];
    m_wdt = w_req.wdt[DAT-1:0];

    s_rdy = '0;
    if (!rst) begin
      s_rdy[sel] = m_rdy;
    end

    w_hs                   = m_vld & m_rdy;
    w_tag_in               = '0;
    w_tag_in.vld           = w_hs;
    w_tag_in.idx[SPL-1:0]  = sel;
  end

  // Response routing tag: either used straight away or carried through a
  // DLY-deep shift register so overlapping responses each keep their port.
  if (DLY == 0) begin : g_dly0
    assign w_tag_out = w_tag_in;
  end else begin : g_dly
    tcb_tag_t pipe_d [DLY];
    tcb_tag_t pipe_q [DLY];

    always_comb begin
      pipe_d[0] = w_tag_in;
      for (int k = 1; k < DLY; k++) begin
        pipe_d[k] = pipe_q[k-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < DLY; k++) begin
          pipe_q[k] <= '0;
        end
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign w_tag_out = pipe_q[DLY-1];
  end

  // Response demux; non-addressed ports see zero.
  always_comb begin
    w_rsp              = '0;
    w_rsp.rdt[DAT-1:0] = m_rdt;
    w_rsp.err          = m_err;

    s_rdt = '0;
    s_err = '0;
    if (!rst && w_tag_out.vld) begin
      s_rdt[w_tag_out.idx[SPL-1:0]] = w_rsp.rdt[DAT-1:0];
      s_err[w_tag_out.idx[SPL-1:0]] = w_rsp.err;
    end
  end

  // Padding bits of the wide package structs are never read.
  assign unused_pad = ^{w_req, w_rsp, w_tag_out};

endmodule
`default_nettype wire

// File: tb/tb_tcb_lib_arbitrated_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_tcb_lib_arbitrated_mux
// Description : Self-checking bench. Two instances share one stimulus
//               stream: A uses the default priorities with DLY=1, B uses
//               inverted priorities with DLY=2. A cycle-level reference
//               model (grant by minimum priority, response slots indexed by
//               due cycle) predicts every output of both instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tcb_lib_arbitrated_mux;

  localparam int unsigned PRI_B [2:0] = '{0, 1, 2};

  logic                 clk = 1'b0;
  logic                 rst;
  logic [2:0]           s_vld, s_wen;
  logic [2:0][31:0]     s_adr, s_wdt;
  logic [2:0][3:0]      s_ben;
  logic                 m_rdy, m_err;
  logic [31:0]          m_rdt;

  logic [2:0]           s_rdy_a, s_err_a, s_rdy_b, s_err_b;
  logic [2:0][31:0]     s_rdt_a, s_rdt_b;
  logic                 m_vld_a, m_wen_a, m_vld_b, m_wen_b;
  logic [31:0]          m_adr_a, m_wdt_a, m_adr_b, m_wdt_b;
  logic [3:0]           m_ben_a, m_ben_b;
  logic [1:0]           sel_a, sel_b;

  always #5 clk = ~clk;

  tcb_lib_arbitrated_mux #(.DLY(1)) dut_a (
    .clk(clk), .rst(rst),
    .s_vld(s_vld), .s_wen(s_wen), .s_adr(s_adr), .s_ben(s_ben), .s_wdt(s_wdt),
    .s_rdy(s_rdy_a), .s_rdt(s_rdt_a), .s_err(s_err_a),
    .m_vld(m_vld_a), .m_wen(m_wen_a), .m_adr(m_adr_a), .m_ben(m_ben_a), .m_wdt(m_wdt_a),
    .m_rdy(m_rdy), .m_rdt(m_rdt), .m_err(m_err), .sel(sel_a)
  );

  tcb_lib_arbitrated_mux #(.DLY(2), .PRI(PRI_B)) dut_b (
    .clk(clk), .rst(rst),
    .s_vld(s_vld), .s_wen(s_wen), .s_adr(s_adr), .s_ben(s_ben), .s_wdt(s_wdt),
    .s_rdy(s_rdy_b), .s_rdt(s_rdt_b), .s_err(s_err_b),
    .m_vld(m_vld_b), .m_wen(m_wen_b), .m_adr(m_adr_b), .m_ben(m_ben_b), .m_wdt(m_wdt_b),
    .m_rdy(m_rdy), .m_rdt(m_rdt), .m_err(m_err), .sel(sel_b)
  );

  // ---------------- reference model ----------------
  int pri_tab [2][3] = '{'{0, 1, 2}, '{2, 1, 0}};  // priority of port p
  int dly_tab [2]    = '{1, 2};
  int last_g  [2];        // last grant
  int slot    [2][16];    // port whose response is due in cycle c%16, -1 none
  int grant_now [2];
  int hs_port   [2];      // port handshaking this cycle, -1 none
  int cyc;
  int checks = 0;
  int errors = 0;

  logic [31:0] adr_tab [3] = '{32'h0, 32'h4, 32'hC};
  logic [31:0] dat_tab [3] = '{32'h03020100, 32'h13121110, 32'h23222120};

  function automatic int ref_grant(input int d, input logic [2:0] v);
    int best = -1;
    for (int i = 0; i < 3; i++)
      if (v[i] && (best < 0 || pri_tab[d][i] < pri_tab[d][best])) best = i;
    return best;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int d, input string n,
                           input logic mv, input logic mw, input logic [31:0] ma,
                           input logic [3:0] mb, input logic [31:0] md,
                           input logic [1:0] sl, input logic [2:0] rdy,
                           input logic [2:0][31:0] rdt, input logic [2:0] er);
    int g, rp;
    logic [2:0] e_rdy;
    g = (|s_vld) ? ref_grant(d, s_vld) : last_g[d];
    grant_now[d] = g;
    hs_port[d]   = (!rst && (|s_vld) && m_rdy) ? g : -1;
    if (rst)                  rp = -1;
    else if (dly_tab[d] == 0) rp = hs_port[d];
    else                      rp = slot[d][cyc % 16];
    e_rdy = '0;
    if (!rst) e_rdy[g] = m_rdy;
    chk({n, "_sel"},   64'(sl), 64'(g));
    chk({n, "_m_vld"}, 64'(mv), 64'(!rst && (|s_vld)));
    chk({n, "_m_wen"}, 64'(mw), 64'(s_wen[g]));
    chk({n, "_m_adr"}, 64'(ma), 64'(s_adr[g]));
    chk({n, "_m_ben"}, 64'(mb), 64'(s_ben[g]));
    chk({n, "_m_wdt"}, 64'(md), 64'(s_wdt[g]));
    chk({n, "_s_rdy"}, 64'(rdy), 64'(e_rdy));
    for (int p = 0; p < 3; p++) begin
      chk({n, "_s_rdt"}, 64'(rdt[p]), (p == rp) ? 64'(m_rdt) : 64'h0);
      chk({n, "_s_err"}, 64'(er[p]),  (p == rp) ? 64'(m_err) : 64'h0);
    end
  endtask

  // Mid-cycle (falling edge): compare both instances against the model.
  task automatic eval_all();
    #4;
    check_dut(0, "a", m_vld_a, m_wen_a, m_adr_a, m_ben_a, m_wdt_a, sel_a, s_rdy_a, s_rdt_a, s_err_a);
    check_dut(1, "b", m_vld_b, m_wen_b, m_adr_b, m_ben_b, m_wdt_b, sel_b, s_rdy_b, s_rdt_b, s_err_b);
  endtask

  // Rising edge: advance the model, then step just past the edge.
  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        last_g[d] = 0;
        for (int k = 0; k < 16; k++) slot[d][k] = -1;
      end else begin
        if (|s_vld) last_g[d] = grant_now[d];
        slot[d][cyc % 16] = -1;
        if (hs_port[d] >= 0 && dly_tab[d] > 0)
          slot[d][(cyc + dly_tab[d]) % 16] = hs_port[d];
      end
    end
    cyc++;
    #1;
  endtask

  task automatic step();
    eval_all();
    tick();
  endtask

  task automatic load_three(input logic wen);
    for (int p = 0; p < 3; p++) begin
      s_adr[p] = adr_tab[p];
      s_wdt[p] = dat_tab[p];
      s_ben[p] = 4'hF;
    end
    s_wen = {3{wen}};
    s_vld = 3'b111;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int rp;
    rst = 1'b1; s_vld = '0; s_wen = '0; s_adr = '0; s_ben = '0; s_wdt = '0;
    m_rdy = 1'b0; m_rdt = '0; m_err = 1'b0;
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      last_g[d] = 0; hs_port[d] = -1; grant_now[d] = 0;
      for (int k = 0; k < 16; k++) slot[d][k] = -1;
    end
    @(posedge clk); #1;

    // Reset state and idle after reset
    step(); step();
    rst = 1'b0;
    step();

    // Simultaneous writes; A serves 0,1,2 on consecutive cycles
    m_rdy = 1'b1;
    load_three(1'b1);
    for (int k = 0; k < 3; k++) begin
      eval_all();
      chk("plan_wr_adr", 64'(m_adr_a), 64'(adr_tab[k]));
      chk("plan_wr_rdy", 64'(s_rdy_a), 64'(3'b001 << k));
      tick();
      if (hs_port[0] >= 0) s_vld[hs_port[0]] = 1'b0;
    end
    step(); step();

    // Simultaneous reads; downstream returns port data one cycle later
    load_three(1'b0);
    for (int k = 0; k < 4; k++) begin
      rp = slot[0][cyc % 16];
      m_rdt = (rp >= 0) ? dat_tab[rp] : 32'h0;
      eval_all();
      if (rp >= 0) chk("plan_rd_rdt", 64'(s_rdt_a[rp]), 64'(dat_tab[rp]));
      tick();
      if (hs_port[0] >= 0) s_vld[hs_port[0]] = 1'b0;
    end
    m_rdt = '0;
    step(); step();

    // Inverted priorities in B: port2 first, port0 last
    load_three(1'b0);
    for (int k = 0; k < 3; k++) begin
      eval_all();
      chk("plan_inv_sel", 64'(sel_b), 64'(2 - k));
      tick();
      if (hs_port[1] >= 0) s_vld[hs_port[1]] = 1'b0;
    end
    s_vld = '0;
    step(); step(); step();

    // Downstream stall with port1 requesting
    s_vld = 3'b010; s_wen = '0; s_adr[1] = 32'h4; m_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      eval_all();
      chk("plan_stall_adr", 64'(m_adr_a), 64'h4);
      chk("plan_stall_rdy", 64'(s_rdy_a[1]), 64'h0);
      tick();
    end
    m_rdy = 1'b1;
    eval_all();
    chk("plan_stall_done", 64'(s_rdy_a[1]), 64'h1);
    tick();
    s_vld = '0;

    // Error on the port1 response
    m_err = 1'b1;
    eval_all();
    chk("plan_err", 64'(s_err_a), 64'(3'b010));
    tick();
    m_err = 1'b0;
    step(); step();

    // Reset while a response is outstanding
    s_vld = 3'b010;
    step();
    s_vld = '0; rst = 1'b1; m_err = 1'b1; m_rdt = 32'hDEADBEEF;
    eval_all();
    chk("plan_rst_err", 64'({s_err_a, s_err_b}), 64'h0);
    tick();
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      eval_all();
      chk("plan_rst_mvld", 64'({m_vld_a, m_vld_b}), 64'h0);
      chk("plan_rst_rsp", 64'({s_err_a, s_err_b}), 64'h0);
      tick();
    end
    m_err = 1'b0;

    // Randomized traffic, protocol kept per A's handshakes
    for (int n = 0; n < 300; n++) begin
      rst   = ($urandom_range(0, 99) < 2);
      m_rdy = ($urandom_range(0, 3) != 0);
      m_rdt = $urandom;
      m_err = ($urandom_range(0, 4) == 0);
      step();
      for (int p = 0; p < 3; p++) begin
        if (hs_port[0] == p) s_vld[p] = 1'b0;
        if (!s_vld[p] && $urandom_range(0, 1) == 1) begin
          s_vld[p] = 1'b1;
          s_wen[p] = 1'($urandom_range(0, 1));
          s_adr[p] = $urandom;
          s_ben[p] = 4'($urandom);
          s_wdt[p] = $urandom;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
